fft_frame_seq: RTL and testbench

Frame sequencer for the xfft_0 core in the AB-end frequency-measurement path. On a start pulse it resets and configures the FFT, streams exactly NFFT ADC samples into the FFT's AXI-Stream input with correct valid/ready/last handshaking, and counts the NFFT output bins. It reports a bin index alongside each output beat and flags frame completion, in single-shot or continuous mode. It replaces the free-running tvalid/aresetn gating around the FFT. The downstream modulus/peak-search logic consumes bin_index/bin_valid.

---
 rtl/fft_frame_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_fft_frame_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_seq.sv
// rtl/fft_frame_seq.sv - frame sequencer for the xfft_0 core: reset, configure, load NFFT samples, count NFFT bins
// Optional UNLOAD watchdog (with its TIMEOUT_CYC parameter) is built only when FFT_SEQ_TIMEOUT_EN is defined.
module fft_frame_seq #(
  parameter int          NFFT_LOG2  = 12,
  parameter logic [7:0]  CFG_WORD   = 8'h01,
  parameter int          RST_CYCLES = 2
`ifdef FFT_SEQ_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYC = 16'd65535
`endif
) (
  input  logic                 fft_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cont_mode,
  input  logic [9:0]           ad_data,
  output logic                 fft_aresetn,
  output logic [7:0]           cfg_tdata,
  output logic                 cfg_tvalid,
  input  logic                 cfg_tready,
  output logic [31:0]          s_tdata,
  output logic                 s_tvalid,
  output logic                 s_tlast,
  input  logic                 s_tready,
  input  logic                 m_tvalid,
  input  logic                 m_tlast,
  output logic [NFFT_LOG2-1:0] bin_index,
  output logic                 bin_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err
);

  localparam int             CW       = NFFT_LOG2 + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'((1 << NFFT_LOG2) - 1);
  localparam int             RW       = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0]  RST_LAST = RW'(RST_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_CONFIG = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ABORT  = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]        in_cnt_q, in_cnt_d;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic [9:0]           sample_q, sample_d;
  logic                 fft_aresetn_q, fft_aresetn_d;
  logic                 cfg_tvalid_q, cfg_tvalid_d;
  logic                 s_tvalid_q, s_tvalid_d;
  logic                 s_tlast_q, s_tlast_d;
  logic [NFFT_LOG2-1:0] bin_index_q, bin_index_d;
  logic                 bin_valid_q, bin_valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_q, err_d;
`ifdef FFT_SEQ_TIMEOUT_EN
  logic [15:0]          wd_q, wd_d;
`endif

  assign fft_aresetn = fft_aresetn_q;
  assign cfg_tdata   = CFG_WORD;
  assign cfg_tvalid  = cfg_tvalid_q;
  assign s_tdata     = {16'h0000, 6'b000000, sample_q};
  assign s_tvalid    = s_tvalid_q;
  assign s_tlast     = s_tlast_q;
  assign bin_index   = bin_index_q;
  assign bin_valid   = bin_valid_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;

  // Every output is a flop, so each transition also loads the outputs of the state being entered.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    sample_d      = sample_q;
    fft_aresetn_d = fft_aresetn_q;
    cfg_tvalid_d  = cfg_tvalid_q;
    s_tvalid_d    = s_tvalid_q;
    s_tlast_d     = s_tlast_q;
    bin_index_d   = bin_index_q;
    bin_valid_d   = 1'b0;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    err_d         = err_q;
`ifdef FFT_SEQ_TIMEOUT_EN
    wd_d          = 16'd0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RESET;
          rst_cnt_d     = '0;
          fft_aresetn_d = 1'b0;
          busy_d        = 1'b1;
          err_d         = 1'b0;
        end
      end

      S_RESET: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          state_d       = S_CONFIG;
          fft_aresetn_d = 1'b1;
          cfg_tvalid_d  = 1'b1;
        end
      end

      S_CONFIG: begin
        if (cfg_tvalid_q && cfg_tready) begin
          state_d      = S_LOAD;
          cfg_tvalid_d = 1'b0;
          s_tvalid_d   = 1'b1;
          s_tlast_d    = 1'b0;
          sample_d     = ad_data;
          in_cnt_d     = '0;
        end
      end

      S_LOAD: begin
        if (s_tvalid_q && s_tready) begin
          sample_d = ad_data;
          in_cnt_d = in_cnt_q + 1'b1;
          if (s_tlast_q) begin
            state_d    = S_UNLOAD;
            s_tvalid_d = 1'b0;
            s_tlast_d  = 1'b0;
            out_cnt_d  = '0;
          end else begin
            s_tlast_d = ((in_cnt_q + 1'b1) == CNT_LAST);
          end
        end
      end

      S_UNLOAD: begin
        if (m_tvalid) begin
          bin_valid_d = 1'b1;
          bin_index_d = out_cnt_q[NFFT_LOG2-1:0];
          out_cnt_d   = out_cnt_q + 1'b1;
          // The local count owns frame length; a misplaced m_tlast only flags an error.
          if (m_tlast != (out_cnt_q == CNT_LAST)) begin
            err_d = 1'b1;
          end
          if (out_cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end
        end
`ifdef FFT_SEQ_TIMEOUT_EN
        else begin
          wd_d = wd_q + 16'd1;
          if ((wd_q + 16'd1) == TIMEOUT_CYC) begin
            state_d       = S_ABORT;
            err_d         = 1'b1;
            fft_aresetn_d = 1'b0;
            rst_cnt_d     = '0;
          end
        end
`endif
      end

      S_DONE: begin
        frame_done_d = 1'b1;
        if (cont_mode) begin
          state_d    = S_LOAD;
          s_tvalid_d = 1'b1;
          s_tlast_d  = 1'b0;
          sample_d   = ad_data;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

`ifdef FFT_SEQ_TIMEOUT_EN
      S_ABORT: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          state_d       = S_IDLE;
          fft_aresetn_d = 1'b1;
          busy_d        = 1'b0;
        end
      end
`endif

      default: begin
        state_d       = S_IDLE;
        fft_aresetn_d = 1'b1;
        cfg_tvalid_d  = 1'b0;
        s_tvalid_d    = 1'b0;
        s_tlast_d     = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      sample_q      <= '0;
      fft_aresetn_q <= 1'b1;
      cfg_tvalid_q  <= 1'b0;
      s_tvalid_q    <= 1'b0;
      s_tlast_q     <= 1'b0;
      bin_index_q   <= '0;
      bin_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
      wd_q          <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      sample_q      <= sample_d;
      fft_aresetn_q <= fft_aresetn_d;
      cfg_tvalid_q  <= cfg_tvalid_d;
      s_tvalid_q    <= s_tvalid_d;
      s_tlast_q     <= s_tlast_d;
      bin_index_q   <= bin_index_d;
      bin_valid_q   <= bin_valid_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
`ifdef FFT_SEQ_TIMEOUT_EN
      wd_q          <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_fft_frame_seq.sv
// tb/tb_fft_frame_seq.sv - scoreboard bench for fft_frame_seq with a behavioural xfft_0 model
// Timeout checks follow FFT_SEQ_TIMEOUT_EN (TIMEOUT_CYC = 100 when defined).
module tb_fft_frame_seq;

  localparam int NFFT = 4096;
  localparam int LAT  = 4;

  logic        fft_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont_mode = 1'b0;
  logic [9:0]  ad_data = '0;
  logic        cfg_tready = 1'b0;
  logic        s_tready = 1'b0;
  logic        m_tvalid = 1'b0;
  logic        m_tlast = 1'b0;
  logic        fft_aresetn;
  logic [7:0]  cfg_tdata;
  logic        cfg_tvalid;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic [11:0] bin_index;
  logic        bin_valid;
  logic        busy;
  logic        frame_done;
  logic        err;

  fft_frame_seq #(
    .NFFT_LOG2  (12),
    .CFG_WORD   (8'h01),
    .RST_CYCLES (2)
`ifdef FFT_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16'd100)
`endif
  ) dut (
    .fft_clk    (fft_clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont_mode  (cont_mode),
    .ad_data    (ad_data),
    .fft_aresetn(fft_aresetn),
    .cfg_tdata  (cfg_tdata),
    .cfg_tvalid (cfg_tvalid),
    .cfg_tready (cfg_tready),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .bin_index  (bin_index),
    .bin_valid  (bin_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  initial forever #5 fft_clk = ~fft_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // model knobs and observation counters
  bit         rdy_rand = 1'b0;
  bit         mis_mode = 1'b0;
  int         stop_after = -1;
  int         in_beats = 0, last_frame_beats = 0, tlast_seen = 0;
  int         bins_seen = 0, frames = 0, cfg_hs = 0;
  int         rst_falls = 0, rst_low_run = 0, rst_low_len = 0;
  int         cfg_wait = 0, lat_cnt = -1, emit_idx = 0;
  bit         emitting = 1'b0;
  bit         prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [9:0] exp_q[$];
  int         bin_q[$];

  // FFT model + scoreboard: drives inputs on the falling edge, then predicts the next rising edge.
  initial forever begin
    @(negedge fft_clk);
    if (!rst_n) begin
      in_beats = 0; emitting = 1'b0; lat_cnt = -1; cfg_wait = 0;
      m_tvalid = 1'b0; m_tlast = 1'b0; cfg_tready = 1'b0; s_tready = 1'b1;
      exp_q.delete(); bin_q.delete(); prev_stall = 1'b0;
    end else begin
      logic accept, cfg_go, cap;
      if (frame_done) frames++;
      if (!fft_aresetn) begin
        if (rst_low_run == 0) rst_falls++;
        rst_low_run++;
      end else if (rst_low_run != 0) begin
        rst_low_len = rst_low_run;
        rst_low_run = 0;
      end

      if (bin_valid) begin
        if (bin_q.size() == 0) check("bin_spurious", 32'd1, 32'd0);
        else check("bin_index", 32'(bin_index), 32'(bin_q.pop_front()));
        bins_seen++;
      end else if (bin_q.size() != 0) begin
        check("bin_missing", 32'd0, 32'd1);
        bin_q.delete();
      end
      if (prev_stall && s_tvalid) check("s_tdata_hold", s_tdata, prev_data);

      if (cfg_tvalid) begin
        cfg_wait++;
        cfg_tready = (cfg_wait >= 3);
      end else begin
        cfg_wait = 0;
        cfg_tready = 1'b0;
      end
      s_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      ad_data  = 10'($urandom);

      if (!fft_aresetn) begin
        emitting = 1'b0; lat_cnt = -1;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
      end else if (lat_cnt == 0) begin
        lat_cnt = -1; emitting = 1'b1; emit_idx = 0;
      end
      if (emitting && fft_aresetn && (stop_after < 0 || emit_idx < stop_after)) begin
        m_tvalid = 1'b1;
        m_tlast  = mis_mode ? (emit_idx == 4000) : (emit_idx == NFFT - 1);
        bin_q.push_back(emit_idx);
        emit_idx++;
        if (emit_idx == NFFT) emitting = 1'b0;
      end else begin
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
      end

      accept = s_tvalid && s_tready;
      cfg_go = cfg_tvalid && cfg_tready;
      if (cfg_go) cfg_hs++;
      if (accept) begin
        if (exp_q.size() == 0) check("s_tdata_underflow", 32'd1, 32'd0);
        else check("s_tdata", s_tdata, {22'h0, exp_q.pop_front()});
        check("s_tlast", 32'(s_tlast), 32'(in_beats == NFFT - 1));
        in_beats++;
        if (s_tlast) begin
          tlast_seen++;
          last_frame_beats = in_beats;
          in_beats = 0;
          exp_q.delete();
          lat_cnt = LAT;
        end
      end
      cap = (accept && !s_tlast) || cfg_go ||
            (bin_valid && (bin_index == 12'(NFFT - 1)) && cont_mode);
      if (cap) exp_q.push_back(ad_data);
      prev_stall = s_tvalid && !s_tready;
      prev_data  = s_tdata;
    end
  end

  initial begin
    #950000;
    $display("FAIL global_timeout: got expired required finish");
    $fatal(1, "bench time limit");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge fft_clk);
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (frames < target && n < 30000) begin
      @(negedge fft_clk);
      n++;
    end
    repeat (2) @(negedge fft_clk);
    check(tag, 32'(frames >= target), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_aresetn"},    32'(fft_aresetn), 32'd1);
    check({tag, "_cfg_tvalid"}, 32'(cfg_tvalid),  32'd0);
    check({tag, "_s_tvalid"},   32'(s_tvalid),    32'd0);
    check({tag, "_s_tlast"},    32'(s_tlast),     32'd0);
    check({tag, "_s_tdata"},    s_tdata,          32'd0);
    check({tag, "_bin_index"},  32'(bin_index),   32'd0);
    check({tag, "_bin_valid"},  32'(bin_valid),   32'd0);
    check({tag, "_busy"},       32'(busy),        32'd0);
    check({tag, "_frame_done"}, 32'(frame_done),  32'd0);
    check({tag, "_err"},        32'(err),         32'd0);
  endtask

  initial begin
    int f0, r0, c0, b0, t0, n;
    repeat (3) @(negedge fft_clk);
    check_reset_vals("por");
    check("cfg_tdata", 32'(cfg_tdata), 32'h01);
    rst_n = 1'b1;
    repeat (2) @(negedge fft_clk);

    // single frame, s_tready tied high
    f0 = frames; r0 = rst_falls; c0 = cfg_hs; b0 = bins_seen; t0 = tlast_seen;
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_aresetn", 32'(fft_aresetn), 32'd0);
    wait_frames(f0 + 1, "single_done");
    check("single_frames", 32'(frames - f0), 32'd1);
    check("single_rst_len", 32'(rst_low_len), 32'd2);
    check("single_rst_falls", 32'(rst_falls - r0), 32'd1);
    check("single_cfg_hs", 32'(cfg_hs - c0), 32'd1);
    check("single_beats", 32'(last_frame_beats), 32'(NFFT));
    check("single_tlasts", 32'(tlast_seen - t0), 32'd1);
    check("single_bins", 32'(bins_seen - b0), 32'(NFFT));
    check("single_busy", 32'(busy), 32'd0);
    check("single_err", 32'(err), 32'd0);

    // random 50% backpressure
    rdy_rand = 1'b1;
    f0 = frames; b0 = bins_seen; t0 = tlast_seen;
    pulse_start();
    wait_frames(f0 + 1, "bp_done");
    check("bp_beats", 32'(last_frame_beats), 32'(NFFT));
    check("bp_tlasts", 32'(tlast_seen - t0), 32'd1);
    check("bp_bins", 32'(bins_seen - b0), 32'(NFFT));
    check("bp_err", 32'(err), 32'd0);
    rdy_rand = 1'b0;

    // continuous mode, dropped during the third frame
    cont_mode = 1'b1;
    f0 = frames; r0 = rst_falls; c0 = cfg_hs; b0 = bins_seen;
    pulse_start();
    wait_frames(f0 + 2, "cont_two");
    check("cont_busy_mid", 32'(busy), 32'd1);
    cont_mode = 1'b0;
    wait_frames(f0 + 3, "cont_three");
    repeat (20) @(negedge fft_clk);
    check("cont_frames", 32'(frames - f0), 32'd3);
    check("cont_rst_falls", 32'(rst_falls - r0), 32'd1);
    check("cont_cfg_hs", 32'(cfg_hs - c0), 32'd1);
    check("cont_bins", 32'(bins_seen - b0), 32'(3 * NFFT));
    check("cont_idle", 32'(busy), 32'd0);

    // m_tlast on beat 4000, plus a start pulse during UNLOAD
    mis_mode = 1'b1;
    f0 = frames; b0 = bins_seen;
    pulse_start();
    n = 0;
    while (bins_seen < b0 + 4050 && n < 30000) begin
      @(negedge fft_clk);
      n++;
    end
    check("mis_reach_4050", 32'(bins_seen >= b0 + 4050), 32'd1);
    check("mis_err_set", 32'(err), 32'd1);
    r0 = rst_falls;
    pulse_start();
    check("unload_start_busy", 32'(busy), 32'd1);
    check("unload_start_err", 32'(err), 32'd1);
    wait_frames(f0 + 1, "mis_done");
    check("mis_bins", 32'(bins_seen - b0), 32'(NFFT));
    check("mis_err_kept", 32'(err), 32'd1);
    check("unload_start_no_reset", 32'(rst_falls - r0), 32'd0);
    check("mis_busy", 32'(busy), 32'd0);
    mis_mode = 1'b0;

    // next start clears err; then reset mid-LOAD
    pulse_start();
    check("start_clears_err", 32'(err), 32'd0);
    n = 0;
    while (in_beats < 100 && n < 1000) begin
      @(negedge fft_clk);
      n++;
    end
    check("midload_reached", 32'(in_beats >= 100), 32'd1);
    f0 = frames;
    rst_n = 1'b0;
    @(negedge fft_clk);
    rst_n = 1'b1;
    check_reset_vals("midload");
    repeat (50) @(negedge fft_clk);
    check("midload_no_done", 32'(frames - f0), 32'd0);
    check("midload_idle", 32'(busy), 32'd0);

    // output stalls after bin 10
    stop_after = 11;
    f0 = frames; b0 = bins_seen; r0 = rst_falls;
    pulse_start();
    n = 0;
    while (bins_seen < b0 + 11 && n < 20000) begin
      @(negedge fft_clk);
      n++;
    end
    check("stall_bins", 32'(bins_seen - b0), 32'd11);
    repeat (300) @(negedge fft_clk);
`ifdef FFT_SEQ_TIMEOUT_EN
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_rst_falls", 32'(rst_falls - r0), 32'd2);
    check("timeout_rst_len", 32'(rst_low_len), 32'd2);
`else
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_err", 32'(err), 32'd0);
    check("stall_rst_falls", 32'(rst_falls - r0), 32'd1);
`endif
    check("stall_no_done", 32'(frames - f0), 32'd0);
    stop_after = -1;
    rst_n = 1'b0;
    repeat (2) @(negedge fft_clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
